adsr_envelope: RTL
==================

Name: adsr_envelope

Overview:
- Per-voice ADSR amplitude envelope, directly downstream of the oscillator.
- Consumes the oscillator's unsigned sample (idle level is mid-scale), generates an 8-bit envelope from a gate signal, and outputs the sample scaled about mid-scale.
- Runs one step per sample_clock cycle and feeds the voice mixer.

Parameters:
- BITDEPTH, 12, width of osc_in and out (unsigned, mid-scale = 2**(BITDEPTH-1)).

Ports:
- sample_clock  in  1  sample-rate clock; every cycle is one sample.
- reset  in  1  asynchronous, active-high reset.
- gate  in  1  note held; a rising edge triggers, a falling edge releases.
- attack_rate  in  8  attack step; per-cycle increment is attack_rate+1.
- decay_rate  in  8  decay step; per-cycle decrement is decay_rate+1.
- sustain_level  in  8  sustain target; the accumulator target is {sustain_level,8'h00}.
- release_rate  in  8  release step; per-cycle decrement is release_rate+1.
- osc_in  in  BITDEPTH  oscillator sample, unsigned.
- out  out  BITDEPTH  scaled sample, unsigned.
- env_level  out  8  current envelope, acc[15:8].
- active  out  1  high when the state is not IDLE.

Behaviour:
- State: 16-bit accumulator acc, states IDLE/ATTACK/DECAY/SUSTAIN/RELEASE, registered gate_d for edge detection.
- Reset (async): state=IDLE, acc=0, gate_d=0, env_level=0, active=0, out=2**(BITDEPTH-1).
- Priority each cycle: reset > rise (gate & ~gate_d) > fall (~gate & gate_d) > state step.
- rise, any state: state<=ATTACK, acc unchanged (retrigger continues from current level, no click).
- fall in ATTACK/DECAY/SUSTAIN: state<=RELEASE, acc unchanged. fall in IDLE/RELEASE: no effect.
- ATTACK: if acc+attack_rate+1 >= 16'hFFFF, then acc<=16'hFFFF and state<=DECAY; else acc+=attack_rate+1. The sum is computed 17 bits wide, with no wrap.
- DECAY: T={sustain_level,8'h00}. If acc <= T+decay_rate+1 (17-bit compare), then acc<=T and state<=SUSTAIN; else acc-=decay_rate+1.
- SUSTAIN: acc<=T every cycle, so a sustain_level change takes effect on the next cycle. If gate is held, the state stays SUSTAIN.
- RELEASE: if acc <= release_rate+1, then acc<=0 and state<=IDLE; else acc-=release_rate+1.
- IDLE: acc holds 0.
- Gate high at reset deassertion counts as a rise on the first clock.
- env_level and active are combinational from the acc and state registers.
- Scaling (registered, 1-cycle latency from osc_in and env_level):
  - c = signed(osc_in) - 2**(BITDEPTH-1), BITDEPTH+1 bits.
  - p = c*env_level, signed.
  - out <= 2**(BITDEPTH-1) + (p >>> 8).
  - The result cannot overflow BITDEPTH bits.
  - env_level=0 gives out = mid-scale exactly.

Optional Feature:
- Macro ADSR_EXP_RELEASE_EN.
- Defined: the RELEASE decrement is d=(acc >> (release_rate[2:0]+1)) + 1, giving an exponential tail; release_rate[7:3] is ignored. Termination rule is unchanged: if acc <= d, then acc<=0 and state<=IDLE.
- Undefined: linear release as specified above.
- All other states are identical in both builds.

Test Plan:
- Attack timing: reset, then attack=255, decay=255, sustain=0x80, gate 0->1 at cycle 0. Expect ATTACK from cycle 1, acc=256k after k steps, acc=0xFFFF and DECAY after 256 steps, env_level=0xFF.
- Decay timing: continue from the previous case. Expect 128 DECAY steps, then acc=0x8000, SUSTAIN, env_level=0x80. Then change sustain to 0x40: env_level=0x40 on the next cycle.
- Release and idle: release=255, gate falls during SUSTAIN at acc 0x8000. Expect RELEASE next cycle, reach IDLE after 128 steps with acc=0, active=0, out=2048 (BITDEPTH=12).
- Scaling at env_level=0xFF: osc_in=0xFFF gives out=4087 one cycle later; osc_in=0x000 gives out=8; osc_in=0x800 gives out=2048.
- Retrigger and reset: gate 1->0->1 during RELEASE at acc 0x3000 leaves acc continuing upward from 0x3000 in ATTACK. Asserting reset mid-ATTACK immediately gives out=2048, env_level=0, IDLE.
- ADSR_EXP_RELEASE_EN build: release_rate=0, RELEASE from acc 0x8000. First step gives acc=0x8000-0x4001=0x3FFF; acc is strictly decreasing each step and reaches IDLE in finite steps.

Source files
------------

// File: rtl/adsr_envelope.sv
`default_nettype none
// ============================================================================
// Module      : adsr_envelope
// Description : Per-voice ADSR amplitude envelope. A 16-bit accumulator is
//               stepped once per sample_clock cycle through IDLE / ATTACK /
//               DECAY / SUSTAIN / RELEASE under control of the gate input.
//               Its upper byte scales the unsigned oscillator sample about
//               mid-scale.
// Ports       : sample_clock  - sample-rate clock, one sample per cycle
//               reset         - asynchronous, active-high reset
//               gate          - note held; rise triggers, fall releases
//               attack_rate   - attack increment minus one
//               decay_rate    - decay decrement minus one
//               sustain_level - sustain target (upper accumulator byte)
//               release_rate  - release decrement minus one (linear build)
//               osc_in        - unsigned oscillator sample
//               out           - scaled unsigned sample, 1-cycle latency
//               env_level     - current envelope, acc[15:8]
//               active        - high whenever the state is not IDLE
// Options     : ADSR_EXP_RELEASE_EN - when defined, RELEASE uses the
//               exponential decrement (acc >> (release_rate[2:0]+1)) + 1.
// Revision    : 1.0 - initial release
// ============================================================================
module adsr_envelope #(
    parameter int BITDEPTH = 12
) (
    input  logic                sample_clock,
    input  logic                reset,
    input  logic                gate,
    input  logic [7:0]          attack_rate,
    input  logic [7:0]          decay_rate,
    input  logic [7:0]          sustain_level,
    input  logic [7:0]          release_rate,
    input  logic [BITDEPTH-1:0] osc_in,
    output logic [BITDEPTH-1:0] out,
    output logic [7:0]          env_level,
    output logic                active
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ATTACK  = 3'd1;
    localparam logic [2:0] c_DECAY   = 3'd2;
    localparam logic [2:0] c_SUSTAIN = 3'd3;
    localparam logic [2:0] c_RELEASE = 3'd4;

    localparam logic [BITDEPTH-1:0] c_MID     = {1'b1, {(BITDEPTH-1){1'b0}}};
    localparam logic [BITDEPTH:0]   c_MID_EXT = {1'b0, c_MID};
    localparam int                  c_PW      = BITDEPTH + 10;

    logic [2:0]          state_q, state_d;
    logic [15:0]         acc_q, acc_d;
    logic                gate_q, gate_d;
    logic [BITDEPTH-1:0] out_q, out_d;

    logic        w_rise, w_fall;
    logic [15:0] w_target;
    logic [16:0] w_att_sum;
    logic [16:0] w_dec_lim;
    logic [16:0] w_rel_dec;

    assign w_rise    = gate & ~gate_q;
    assign w_fall    = ~gate & gate_q;
    assign w_target  = {sustain_level, 8'h00};
    // All step arithmetic is 17 bits wide so neither the attack sum nor the
    // decay threshold can wrap.
    assign w_att_sum = {1'b0, acc_q} + {9'd0, attack_rate} + 17'd1;
    assign w_dec_lim = {1'b0, w_target} + {9'd0, decay_rate} + 17'd1;

`ifdef ADSR_EXP_RELEASE_EN
    logic [3:0] w_shamt;
    logic       w_unused_rel;
    assign w_shamt      = {1'b0, release_rate[2:0]} + 4'd1;
    // The +1 keeps the decrement non-zero so the tail always terminates.
    assign w_rel_dec    = {1'b0, acc_q >> w_shamt} + 17'd1;
    assign w_unused_rel = ^release_rate[7:3];
`else
    assign w_rel_dec    = {9'd0, release_rate} + 17'd1;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        gate_d  = gate;
        if (w_rise) begin
            // Retrigger keeps the current level to avoid a click.
            state_d = c_ATTACK;
        end else if (w_fall && (state_q == c_ATTACK || state_q == c_DECAY ||
                                state_q == c_SUSTAIN)) begin
            state_d = c_RELEASE;
        end else begin
            case (state_q)
                c_ATTACK: begin
                    if (w_att_sum >= 17'h0FFFF) begin
                        acc_d   = 16'hFFFF;
                        state_d = c_DECAY;
                    end else begin
                        acc_d = w_att_sum[15:0];
                    end
                end
                c_DECAY: begin
                    if ({1'b0, acc_q} <= w_dec_lim) begin
                        acc_d   = w_target;
                        state_d = c_SUSTAIN;
                    end else begin
                        acc_d = acc_q - ({8'd0, decay_rate} + 16'd1);
                    end
                end
                c_SUSTAIN: begin
                    acc_d = w_target;
                end
                c_RELEASE: begin
                    if ({1'b0, acc_q} <= w_rel_dec) begin
                        acc_d   = 16'h0000;
                        state_d = c_IDLE;
                    end else begin
                        acc_d = acc_q - w_rel_dec[15:0];
                    end
                end
                default: begin
                    acc_d   = 16'h0000;
                    state_d = c_IDLE;
                end
            endcase
        end
    end

    assign env_level = acc_q[15:8];
    assign active    = (state_q != c_IDLE);

    // Scaling: centre the sample, multiply by the envelope, shift back down.
    // Operands are sign/zero-extended to the product width so the low bits
    // of the product are the exact signed result.
    logic [BITDEPTH:0] w_c;
    logic [c_PW-1:0]   w_c_ext, w_e_ext, w_p;
    logic              w_unused_p;

    assign w_c        = {1'b0, osc_in} - c_MID_EXT;
    assign w_c_ext    = {{9{w_c[BITDEPTH]}}, w_c};
    assign w_e_ext    = {{(BITDEPTH+2){1'b0}}, env_level};
    assign w_p        = w_c_ext * w_e_ext;
    assign w_unused_p = ^{w_p[c_PW-1:BITDEPTH+8], w_p[7:0]};

    always_comb begin
        out_d = w_p[BITDEPTH+7:8] + c_MID;
    end

    assign out = out_q;

    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            state_q <= c_IDLE;
            acc_q   <= 16'h0000;
            gate_q  <= 1'b0;
            out_q   <= c_MID;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            gate_q  <= gate_d;
            out_q   <= out_d;
        end
    end

endmodule
`default_nettype wire
